filter_buf_loader: RTL and testbench
====================================

# filter_buf_loader

- Buffer-manager stage directly downstream of the CNN layer controller.
- On each filter-load request pulse, it fetches the weights of one tiled output channel from external memory and writes them into the on-chip filter buffer.
- It then raises the buffer-manager side of the controller's channel-sync handshake.
- It sits between the controller (`o_fb_load_req`, `o_chn_out`, `o_ctrl_csync_run`) and the memory read port / filter buffer SRAM.

## Interface
- `W_CHANNEL`, 8, width of tiled channel counts/indices
- `W_ADDR`, 32, memory byte-address width
- `W_DATA`, 32, memory/filter-buffer word width
- `W_FB_ADDR`, 12, filter buffer word-address width
- `KERNEL_WORDS`, 9, words per (input tile, output tile) kernel
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `q_channel`  in  W_CHANNEL  tiled input channel count, stable during layer
- `q_filter_base`  in  W_ADDR  byte address of layer weights, stable during layer
- `i_load_req`  in  1  one-cycle load request (from controller `o_fb_load_req`)
- `i_chn_out`  in  W_CHANNEL  output tile to load, sampled with `i_load_req`
- `i_csync_run`  in  1  controller in CSYNC state
- `o_rd_req_valid`  out  1  memory read request valid
- `i_rd_req_ready`  in  1  memory accepts request
- `o_rd_req_addr`  out  W_ADDR  burst start byte address
- `o_rd_req_len`  out  W_FB_ADDR+1  burst length in words
- `i_rd_data_valid`  in  1  read beat valid
- `i_rd_data`  in  W_DATA  read beat
- `o_rd_data_ready`  out  1  loader accepts beat
- `o_fb_we`  out  1  filter buffer write enable
- `o_fb_addr`  out  W_FB_ADDR  filter buffer write address
- `o_fb_wdata`  out  W_DATA  filter buffer write data
- `o_csync_done`  out  1  load complete (to controller `bm_csync_done`)
- `o_busy`  out  1  state != IDLE

## Operation
- Tile size: `tile_words = q_channel * KERNEL_WORDS`, computed in W_FB_ADDR+1 bits.
- Burst address: `o_rd_req_addr = q_filter_base + i_chn_out * tile_words * (W_DATA/8)`, computed in W_ADDR bits with wrap on overflow, registered at request capture.
- FSM states: IDLE, REQ, RECV, DONE.
- IDLE:
  - On `i_load_req`, capture `i_chn_out`, address and length.
  - If `tile_words == 0`, go to DONE; otherwise go to REQ.
  - Requests arriving in any other state are ignored.
- REQ:
  - `o_rd_req_valid` = 1, with address and length held stable.
  - On `i_rd_req_ready`, go to RECV.
- RECV:
  - `o_rd_data_ready` = 1.
  - Each accepted beat (valid & ready) writes the buffer at address `wr_cnt`, then `wr_cnt` increments. `wr_cnt` resets to 0 on entering REQ.
  - After the beat with `wr_cnt == tile_words-1` is accepted, `o_rd_data_ready` drops the next cycle and the FSM goes to DONE.
  - Excess beats are never accepted.
- DONE:
  - `o_csync_done` = 1, held while `i_csync_run` = 1.
  - When `i_csync_run` = 0, go to IDLE; `o_csync_done` drops the same cycle the state leaves DONE.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-burst abandons the burst. The memory side must be reset together with the loader.

## Timing
- `i_load_req` at cycle t puts the FSM in REQ at t+1, with `o_rd_req_valid` = 1 at t+1.
- Request handshake at cycle r puts the FSM in RECV at r+1.
- Beat accepted at cycle b produces `o_fb_we`/`o_fb_addr`/`o_fb_wdata` registered at b+1 (one-cycle latency).
- Last beat accepted at cycle b:
  - Last buffer write is visible at b+1.
  - FSM is in DONE and `o_csync_done` = 1 at b+1, so the buffer holds complete data when done is seen.
- Zero-length tile: `o_csync_done` = 1 at t+1 and no memory traffic is issued.
- Gaps in `i_rd_data_valid` stall `wr_cnt` only, with no write strobes during the gap.

## Configuration
- Macro: `FBL_ERR_CHECK_EN`.
- Defined: adds output `o_err` (1 bit, reset 0, sticky until `rstn`). It is set when either:
  - `i_load_req` arrives while not in IDLE, or
  - `tile_words > 2^W_FB_ADDR`; in this case the load still proceeds and `wr_cnt` wraps the buffer address.
- Undefined: no `o_err` port and no check logic; behaviour is otherwise identical.

## Test plan
- **Basic load.** Setup: `q_channel`=2, base=0x1000, chn_out=3, ready always 1. Required response:
  - Request address 0x1000+3·18·4=0x10D8, length 18.
  - 18 writes to fb addr 0..17 with matching data.
  - Done one cycle after the last beat.
- **Backpressure.** Setup: `i_rd_req_ready` held low 5 cycles; data valid toggled 1-0-1. Required response:
  - Request fields stable until accepted.
  - Writes occur only on valid cycles; addresses are contiguous.
- **Done handshake.** Setup: `i_csync_run` held 1 for 10 cycles after done. Required response:
  - `o_csync_done` stays 1 for all 10 cycles.
  - It falls, and `o_busy` falls, in the cycle after `i_csync_run`=0.
- **Zero channel.** Setup: `q_channel`=0, load_req. Required response: `o_rd_req_valid` never asserted; done at t+1.
- **Reset mid-burst.** Setup: `rstn` low after 4 of 18 beats. Required response:
  - All outputs 0, FSM IDLE.
  - A new load_req completes a full 18-word load from address 0.
- **Error check** (`FBL_ERR_CHECK_EN`). Setup: load_req while in RECV. Required response:
  - Request ignored; `o_err`=1 and stays 1.
  - The current load completes unchanged.

Source files
------------

// File: rtl/filter_buf_loader_if.sv
// Memory read port and filter-buffer write port of filter_buf_loader.
// master = loader side, slave = memory / buffer side.
interface filter_buf_loader_if #(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int W_FB_ADDR = 12
);
  logic                 o_rd_req_valid;
  logic                 i_rd_req_ready;
  logic [W_ADDR-1:0]    o_rd_req_addr;
  logic [W_FB_ADDR:0]   o_rd_req_len;
  logic                 i_rd_data_valid;
  logic [W_DATA-1:0]    i_rd_data;
  logic                 o_rd_data_ready;
  logic                 o_fb_we;
  logic [W_FB_ADDR-1:0] o_fb_addr;
  logic [W_DATA-1:0]    o_fb_wdata;

  modport master (
    output o_rd_req_valid, o_rd_req_addr, o_rd_req_len, o_rd_data_ready,
    output o_fb_we, o_fb_addr, o_fb_wdata,
    input  i_rd_req_ready, i_rd_data_valid, i_rd_data
  );

  modport slave (
    input  o_rd_req_valid, o_rd_req_addr, o_rd_req_len, o_rd_data_ready,
    input  o_fb_we, o_fb_addr, o_fb_wdata,
    output i_rd_req_ready, i_rd_data_valid, i_rd_data
  );
endinterface

// File: rtl/filter_buf_loader.sv
// Loads one tiled output channel of weights from memory into the filter buffer, then
// raises the channel-sync done. Optional sticky error flag under FBL_ERR_CHECK_EN.
module filter_buf_loader #(
  parameter int W_CHANNEL    = 8,
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int W_FB_ADDR    = 12,
  parameter int KERNEL_WORDS = 9
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [W_CHANNEL-1:0] q_channel,
  input  logic [W_ADDR-1:0]    q_filter_base,
  input  logic                 i_load_req,
  input  logic [W_CHANNEL-1:0] i_chn_out,
  input  logic                 i_csync_run,
  filter_buf_loader_if.master  mem,
  output logic                 o_csync_done,
  output logic                 o_busy
`ifdef FBL_ERR_CHECK_EN
  ,
  output logic                 o_err
`endif
);
  localparam int WL = W_FB_ADDR + 1;

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t            state, state_nx;
  logic [WL-1:0]     tile_words, len_q, wr_cnt;
  logic [W_ADDR-1:0] burst_addr, addr_q;
  logic              capture, beat, last_beat;

  assign tile_words = WL'(q_channel) * WL'(KERNEL_WORDS);
  assign burst_addr = q_filter_base
                    + W_ADDR'(i_chn_out) * W_ADDR'(tile_words) * W_ADDR'(W_DATA / 8);

  assign capture   = (state == IDLE) && i_load_req;
  assign beat      = (state == RECV) && mem.i_rd_data_valid;
  assign last_beat = beat && (wr_cnt == len_q - WL'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_load_req)          state_nx = (tile_words == '0) ? DONE : REQ;
      REQ:  if (mem.i_rd_req_ready)  state_nx = RECV;
      RECV: if (last_beat)           state_nx = DONE;
      DONE: if (!i_csync_run)        state_nx = IDLE;
      default:                       state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem.o_rd_req_valid  = (state == REQ);
    mem.o_rd_data_ready = (state == RECV);
    o_csync_done        = (state == DONE);
    o_busy              = (state != IDLE);
  end

  assign mem.o_rd_req_addr = addr_q;
  assign mem.o_rd_req_len  = len_q;

  // Beat index doubles as buffer address; the top bit only matters for
  // oversized tiles, where the buffer address wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q         <= '0;
      len_q          <= '0;
      wr_cnt         <= '0;
      mem.o_fb_we    <= 1'b0;
      mem.o_fb_addr  <= '0;
      mem.o_fb_wdata <= '0;
    end else begin
      mem.o_fb_we <= beat;
      if (capture) begin
        addr_q <= burst_addr;
        len_q  <= tile_words;
        wr_cnt <= '0;
      end else if (beat) begin
        wr_cnt <= wr_cnt + WL'(1);
      end
      if (beat) begin
        mem.o_fb_addr  <= wr_cnt[W_FB_ADDR-1:0];
        mem.o_fb_wdata <= mem.i_rd_data;
      end
    end
  end

`ifdef FBL_ERR_CHECK_EN
  localparam logic [WL-1:0] FB_CAP = {1'b1, {W_FB_ADDR{1'b0}}};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      o_err <= 1'b0;
    else if (i_load_req && ((state != IDLE) || (tile_words > FB_CAP)))
      o_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_filter_buf_loader.sv
// Self-checking bench for filter_buf_loader: behavioural tile/address model plus a
// cycle-stepped controller and memory driver with randomized data and valid gaps.
module tb_filter_buf_loader;
  localparam int W_CHANNEL = 8, W_ADDR = 32, W_DATA = 32, W_FB_ADDR = 12, KW = 9;

  logic        clk = 1'b0, rstn = 1'b0;
  logic [7:0]  q_channel = '0, i_chn_out = '0;
  logic [31:0] q_filter_base = '0;
  logic        i_load_req = 1'b0, i_csync_run = 1'b0;
  logic        o_csync_done, o_busy;
`ifdef FBL_ERR_CHECK_EN
  logic        o_err;
`endif
  int vec = 0, errs = 0;

  filter_buf_loader_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_FB_ADDR(W_FB_ADDR)) mif ();

  filter_buf_loader #(
    .W_CHANNEL(W_CHANNEL), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .W_FB_ADDR(W_FB_ADDR), .KERNEL_WORDS(KW)
  ) dut (
    .clk(clk), .rstn(rstn), .q_channel(q_channel), .q_filter_base(q_filter_base),
    .i_load_req(i_load_req), .i_chn_out(i_chn_out), .i_csync_run(i_csync_run),
    .mem(mif), .o_csync_done(o_csync_done), .o_busy(o_busy)
`ifdef FBL_ERR_CHECK_EN
    , .o_err(o_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic int ref_tile(input int qch);
    return (qch * KW) % (1 << (W_FB_ADDR + 1));
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] base, input int chn, input int tile);
    longint a;
    a = longint'(base) + longint'(chn) * longint'(tile) * 4;
    return a[31:0];
  endfunction

  // One load from request to release. abort_at >= 0 pulls rstn low once that many
  // beats were accepted; inject_at >= 0 issues a stray load request at that point.
  task automatic run_load(input int qch, input int chn, input logic [31:0] base,
                          input int req_wait, input int vmode, input int hold,
                          input int abort_at, input int inject_at, input string tag);
    int tile, sent, pidx, cyc;
    logic [31:0] ea;
    logic [31:0] dq[];
    bit pwe, v, inj, fin;
    tile = ref_tile(qch);
    ea   = ref_addr(base, chn, tile);
    dq   = new[(tile > 0) ? tile : 1];
    foreach (dq[i]) dq[i] = $urandom;
    q_channel = 8'(qch); q_filter_base = base; i_chn_out = 8'(chn);
    i_load_req = 1'b1; i_csync_run = 1'b1;
    @(negedge clk);
    i_load_req = 1'b0;
    if (tile == 0) begin
      vec++;
      if ({o_csync_done, o_busy, mif.o_rd_req_valid} !== 3'b110) begin
        errs++; $display("FAIL %s zero_done: got %b want 110", tag, {o_csync_done, o_busy, mif.o_rd_req_valid});
      end
    end else begin
      for (int k = 0; k <= req_wait; k++) begin
        vec++;
        if ({mif.o_rd_req_valid, mif.o_rd_req_addr, mif.o_rd_req_len, mif.o_rd_data_ready, o_csync_done}
            !== {1'b1, ea, 13'(tile), 2'b00}) begin
          errs++;
          $display("FAIL %s req_hold[%0d]: got v=%b a=%h l=%0d want v=1 a=%h l=%0d", tag, k,
                   mif.o_rd_req_valid, mif.o_rd_req_addr, mif.o_rd_req_len, ea, tile);
        end
        mif.i_rd_req_ready = (k == req_wait);
        @(negedge clk);
      end
      mif.i_rd_req_ready = 1'b0;
      sent = 0; pidx = 0; pwe = 0; cyc = 0; inj = 0; fin = 0;
      while (cyc < 4000 && !fin) begin
        cyc++;
        vec++;
        if (mif.o_fb_we !== pwe ||
            (pwe && {mif.o_fb_addr, mif.o_fb_wdata} !== {12'(pidx), dq[pidx]})) begin
          errs++;
          $display("FAIL %s fb_write: got we=%b a=%0d d=%h want we=%b a=%0d d=%h", tag,
                   mif.o_fb_we, mif.o_fb_addr, mif.o_fb_wdata, pwe, pidx, dq[pidx]);
        end
        if (pwe && pidx == tile - 1) begin
          fin = 1;
        end else begin
          vec++;
          if ({mif.o_rd_data_ready, mif.o_rd_req_valid, o_csync_done} !== 3'b100) begin
            errs++; $display("FAIL %s recv_state: got %b want 100", tag,
                             {mif.o_rd_data_ready, mif.o_rd_req_valid, o_csync_done});
          end
          if (sent == abort_at) begin
            rstn = 1'b0; mif.i_rd_data_valid = 1'b0;
            return;
          end
          i_load_req = 1'b0;
          if (sent == inject_at && !inj) begin
            inj = 1; i_load_req = 1'b1; i_chn_out = 8'(chn + 1);
          end
          case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 1);
            default: v = ($urandom_range(0, 2) != 0);
          endcase
          mif.i_rd_data_valid = v;
          mif.i_rd_data       = v ? dq[sent] : $urandom;
          pwe = v; pidx = sent;
          if (v) sent++;
          @(negedge clk);
        end
      end
      if (!fin) begin
        errs++; $display("FAIL %s timeout: got %0d beats want %0d", tag, sent, tile);
      end
    end
    i_load_req = 1'b0;
    mif.i_rd_data_valid = 1'b1;
    mif.i_rd_data = $urandom;
    for (int k = 0; k < hold; k++) begin
      vec++;
      if ({o_csync_done, o_busy, mif.o_rd_data_ready, mif.o_rd_req_valid} !== 4'b1100) begin
        errs++; $display("FAIL %s done_hold[%0d]: got %b want 1100", tag, k,
                         {o_csync_done, o_busy, mif.o_rd_data_ready, mif.o_rd_req_valid});
      end
      @(negedge clk);
      vec++;
      if (mif.o_fb_we !== 1'b0) begin
        errs++; $display("FAIL %s excess_write: got we=%b want 0", tag, mif.o_fb_we);
      end
    end
    vec++;
    if ({o_csync_done, o_busy, mif.o_rd_data_ready, mif.o_rd_req_valid} !== 4'b1100) begin
      errs++; $display("FAIL %s done_level: got %b want 1100", tag,
                       {o_csync_done, o_busy, mif.o_rd_data_ready, mif.o_rd_req_valid});
    end
    i_csync_run = 1'b0;
    @(negedge clk);
    mif.i_rd_data_valid = 1'b0;
    vec++;
    if ({o_csync_done, o_busy, mif.o_rd_req_valid} !== 3'b000) begin
      errs++; $display("FAIL %s done_release: got %b want 000", tag,
                       {o_csync_done, o_busy, mif.o_rd_req_valid});
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    @(negedge clk);
    vec++;
    if ({mif.o_rd_req_valid, mif.o_rd_req_addr, mif.o_rd_req_len, mif.o_rd_data_ready,
         mif.o_fb_we, mif.o_fb_addr, mif.o_fb_wdata, o_csync_done, o_busy} !== '0) begin
      errs++; $display("FAIL reset_outputs: got v=%b a=%h l=%0d r=%b we=%b done=%b busy=%b want all 0",
                       mif.o_rd_req_valid, mif.o_rd_req_addr, mif.o_rd_req_len,
                       mif.o_rd_data_ready, mif.o_fb_we, o_csync_done, o_busy);
    end
`ifdef FBL_ERR_CHECK_EN
    vec++;
    if (o_err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", o_err); end
`endif
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_load(2, 3, 32'h0000_1000, 0, 0, 0, -1, -1, "basic");
  endtask

  task automatic test_backpressure;
    run_load(2, 5, 32'h2000_0000, 5, 1, 2, -1, -1, "backpressure");
  endtask

  task automatic test_done_handshake;
    run_load(1, 7, 32'h0000_0400, 1, 0, 10, -1, -1, "done_hs");
  endtask

  task automatic test_zero_channel;
    run_load(0, 4, 32'h0000_0040, 0, 0, 3, -1, -1, "zero_chn");
  endtask

  task automatic test_reset_mid_burst;
    run_load(2, 3, 32'h0000_1000, 0, 0, 0, 4, -1, "mid_burst");
    #1;
    vec++;
    if ({mif.o_rd_req_valid, mif.o_rd_req_addr, mif.o_rd_req_len, mif.o_rd_data_ready,
         mif.o_fb_we, o_csync_done, o_busy} !== '0) begin
      errs++; $display("FAIL mid_burst_reset: got v=%b a=%h l=%0d r=%b we=%b done=%b busy=%b want all 0",
                       mif.o_rd_req_valid, mif.o_rd_req_addr, mif.o_rd_req_len,
                       mif.o_rd_data_ready, mif.o_fb_we, o_csync_done, o_busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    i_csync_run = 1'b0;
    @(negedge clk);
    run_load(2, 0, 32'h0000_0000, 0, 0, 0, -1, -1, "after_reset");
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++)
      run_load($urandom_range(0, 3), $urandom_range(0, 255), $urandom,
               $urandom_range(0, 3), 2, $urandom_range(0, 3), -1, -1, "random");
  endtask

`ifdef FBL_ERR_CHECK_EN
  task automatic test_err;
    vec++;
    if (o_err !== 1'b0) begin errs++; $display("FAIL err_clean: got %b want 0", o_err); end
    run_load(2, 1, 32'h0000_3000, 1, 0, 1, -1, 5, "err_inject");
    vec++;
    if (o_err !== 1'b1) begin errs++; $display("FAIL err_set: got %b want 1", o_err); end
    run_load(1, 2, 32'h0000_5000, 0, 0, 0, -1, -1, "err_sticky");
    vec++;
    if (o_err !== 1'b1) begin errs++; $display("FAIL err_sticky: got %b want 1", o_err); end
    test_reset;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mif.i_rd_req_ready = 1'b0; mif.i_rd_data_valid = 1'b0; mif.i_rd_data = '0;
    test_reset;
    test_basic;
    test_backpressure;
    test_done_handshake;
    test_zero_channel;
    test_reset_mid_burst;
    test_random;
`ifdef FBL_ERR_CHECK_EN
    test_err;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
